xcvr_rst_seq: RTL and testbench

Transceiver reset sequencer for the 10GBASE-R datapath. It drives the fPLL powerdown input of the clock/reset block and consumes that block's PLL status outputs. It steps the transceiver TX and RX analog and digital resets through the vendor-mandated release order, and re-sequences automatically when PLL or CDR lock is lost. It sits between the clock/reset block and the PHY instance and runs on the global clock.

---
 rtl/xcvr_rst_pkg.sv | 28 ++
 rtl/xcvr_rst_seq_sync_bit.sv | 24 ++
 rtl/xcvr_rst_seq.sv | 173 +++++++++++++++++
 tb/tb_xcvr_rst_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/xcvr_rst_pkg.sv
// Shared types and helpers for the transceiver reset sequencer.
package xcvr_rst_pkg;

  typedef enum logic [2:0] {
    S_PLL_PD   = 3'd0,
    S_PLL_LOCK = 3'd1,
    S_TX_ANA   = 3'd2,
    S_TX_DIG   = 3'd3,
    S_RX_ANA   = 3'd4,
    S_RX_CDR   = 3'd5,
    S_RX_DIG   = 3'd6,
    S_READY    = 3'd7
  } state_t;

  // Largest of five values; sizes the shared dwell/qualify counter.
  function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d,
                                       input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/xcvr_rst_seq_sync_bit.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // First flop may go metastable; second flop presents a settled value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xcvr_rst_seq.sv
// Transceiver reset sequencer: fPLL bring-up, then TX and RX reset release
// in vendor order, re-sequencing on loss of PLL or CDR lock.
module xcvr_rst_seq
  import xcvr_rst_pkg::*;
#(
  parameter int unsigned PD_CYCLES   = 1000,
  parameter int unsigned LOCK_CYCLES = 500,
  parameter int unsigned ANA_CYCLES  = 100,
  parameter int unsigned DIG_CYCLES  = 100,
  parameter int unsigned LTD_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       pll_cal_busy,
  input  logic       tx_cal_busy,
  input  logic       rx_cal_busy,
  input  logic       rx_is_lockedtodata,
  output logic       pll_powerdown,
  output logic       tx_analogreset,
  output logic       tx_digitalreset,
  output logic       rx_analogreset,
  output logic       rx_digitalreset,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic [2:0] state
);

  localparam int unsigned CNT_W =
    $clog2(max5(PD_CYCLES, LOCK_CYCLES, ANA_CYCLES, DIG_CYCLES, LTD_CYCLES)) + 1;

  logic locked_s, pll_busy_s, tx_busy_s, rx_busy_s, ltd_s;

  sync_bit #(.RST_VAL(1'b0)) u_sync_locked   (.clk(clk), .rst_n(rst_n), .d(pll_locked),         .q(locked_s));
  sync_bit #(.RST_VAL(1'b1)) u_sync_pll_busy (.clk(clk), .rst_n(rst_n), .d(pll_cal_busy),       .q(pll_busy_s));
  sync_bit #(.RST_VAL(1'b1)) u_sync_tx_busy  (.clk(clk), .rst_n(rst_n), .d(tx_cal_busy),        .q(tx_busy_s));
  sync_bit #(.RST_VAL(1'b1)) u_sync_rx_busy  (.clk(clk), .rst_n(rst_n), .d(rx_cal_busy),        .q(rx_busy_s));
  sync_bit #(.RST_VAL(1'b0)) u_sync_ltd      (.clk(clk), .rst_n(rst_n), .d(rx_is_lockedtodata), .q(ltd_s));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pd_d, tx_ana_d, tx_dig_d, rx_ana_d, rx_dig_d, tx_rdy_d, rx_rdy_d;
  logic             lock_ok, pll_fault, rx_fault;

  assign lock_ok   = locked_s & ~pll_busy_s;
  assign pll_fault = ~locked_s &
                     (state_q inside {S_TX_ANA, S_TX_DIG, S_RX_ANA, S_RX_CDR, S_RX_DIG, S_READY});
  assign rx_fault  = ~ltd_s & (state_q inside {S_RX_DIG, S_READY});

  assign state = state_q;

  // State, counter and decoded outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_PLL_PD;
      cnt_q           <= '0;
      pll_powerdown   <= 1'b1;
      tx_analogreset  <= 1'b1;
      tx_digitalreset <= 1'b1;
      rx_analogreset  <= 1'b1;
      rx_digitalreset <= 1'b1;
      tx_ready        <= 1'b0;
      rx_ready        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_powerdown   <= pd_d;
      tx_analogreset  <= tx_ana_d;
      tx_digitalreset <= tx_dig_d;
      rx_analogreset  <= rx_ana_d;
      rx_digitalreset <= rx_dig_d;
      tx_ready        <= tx_rdy_d;
      rx_ready        <= rx_rdy_d;
    end
  end

  // Next state and counter; faults override, counter clears on any state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_PLL_PD: begin
        if (cnt_q == CNT_W'(PD_CYCLES - 1)) state_d = S_PLL_LOCK;
        else                                cnt_d   = cnt_q + CNT_W'(1);
      end
      S_PLL_LOCK: begin
        if (!lock_ok)                            cnt_d   = '0;
        else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) state_d = S_TX_ANA;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_TX_ANA: begin
        if (cnt_q == CNT_W'(ANA_CYCLES - 1)) state_d = S_TX_DIG;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_TX_DIG: begin
        if (tx_busy_s)                            cnt_d   = '0;
        else if (cnt_q == CNT_W'(DIG_CYCLES - 1)) state_d = S_RX_ANA;
        else                                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RX_ANA: begin
        if (cnt_q == CNT_W'(ANA_CYCLES - 1)) state_d = S_RX_CDR;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RX_CDR: begin
        if (!(ltd_s && !rx_busy_s))               cnt_d   = '0;
        else if (cnt_q == CNT_W'(LTD_CYCLES - 1)) state_d = S_RX_DIG;
        else                                      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RX_DIG: begin
        if (cnt_q == CNT_W'(DIG_CYCLES - 1)) state_d = S_READY;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_PLL_PD;
      end
    endcase

    if (pll_fault)     state_d = S_PLL_PD;
    else if (rx_fault) state_d = S_RX_ANA;

    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from the next state so outputs move on the same edge as state.
  always_comb begin
    pd_d     = 1'b0;
    tx_ana_d = 1'b0;
    tx_dig_d = 1'b0;
    rx_ana_d = 1'b0;
    rx_dig_d = 1'b1;
    tx_rdy_d = 1'b0;
    rx_rdy_d = 1'b0;
    unique case (state_d)
      S_PLL_PD: begin
        pd_d     = 1'b1;
        tx_ana_d = 1'b1;
        tx_dig_d = 1'b1;
        rx_ana_d = 1'b1;
      end
      S_PLL_LOCK, S_TX_ANA: begin
        tx_ana_d = 1'b1;
        tx_dig_d = 1'b1;
        rx_ana_d = 1'b1;
      end
      S_TX_DIG: begin
        tx_dig_d = 1'b1;
        rx_ana_d = 1'b1;
      end
      S_RX_ANA: begin
        tx_rdy_d = 1'b1;
        rx_ana_d = 1'b1;
      end
      S_RX_CDR, S_RX_DIG: begin
        tx_rdy_d = 1'b1;
      end
      S_READY: begin
        rx_dig_d = 1'b0;
        tx_rdy_d = 1'b1;
        rx_rdy_d = 1'b1;
      end
      default: begin
        pd_d     = 1'b1;
        tx_ana_d = 1'b1;
        tx_dig_d = 1'b1;
        rx_ana_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_xcvr_rst_seq.sv
// Directed bench for the transceiver reset sequencer.
module tb_xcvr_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata;
  logic       pll_powerdown, tx_analogreset, tx_digitalreset, rx_analogreset, rx_digitalreset;
  logic       tx_ready, rx_ready;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int e0;

  xcvr_rst_seq #(
    .PD_CYCLES(8), .LOCK_CYCLES(4), .ANA_CYCLES(4), .DIG_CYCLES(4), .LTD_CYCLES(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pll_locked(pll_locked), .pll_cal_busy(pll_cal_busy),
    .tx_cal_busy(tx_cal_busy), .rx_cal_busy(rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .pll_powerdown(pll_powerdown), .tx_analogreset(tx_analogreset),
    .tx_digitalreset(tx_digitalreset), .rx_analogreset(rx_analogreset),
    .rx_digitalreset(rx_digitalreset), .tx_ready(tx_ready), .rx_ready(rx_ready),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  // Packed view {state, pd, tx_ana, tx_dig, rx_ana, rx_dig, tx_rdy, rx_rdy}.
  function automatic logic [9:0] outs();
    return {state, pll_powerdown, tx_analogreset, tx_digitalreset,
            rx_analogreset, rx_digitalreset, tx_ready, rx_ready};
  endfunction

  localparam logic [9:0] RST_OUTS = {3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk(tag, 32'(outs()), 32'(RST_OUTS));
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    rst_n              = 1'b1;
    pll_locked         = 1'b1;
    pll_cal_busy       = 1'b0;
    tx_cal_busy        = 1'b0;
    rx_cal_busy        = 1'b0;
    rx_is_lockedtodata = 1'b1;
    #1;

    // Clean bring-up
    do_reset("reset_values");
    run_to(7);  chk("pd_high_e7", 32'(pll_powerdown), 32'd1);
    run_to(8);  chk("pd_low_e8", 32'(pll_powerdown), 32'd0);
                chk("state_lock_e8", 32'(state), 32'd1);
    run_to(15); chk("txana_high_e15", 32'(tx_analogreset), 32'd1);
    run_to(16); chk("txana_low_e16", 32'(tx_analogreset), 32'd0);
                chk("txdig_high_e16", 32'(tx_digitalreset), 32'd1);
    run_to(19); chk("txrdy_low_e19", 32'(tx_ready), 32'd0);
    run_to(20); chk("txrdy_high_e20", 32'(tx_ready), 32'd1);
                chk("rxana_high_e20", 32'(rx_analogreset), 32'd1);
    run_to(33); chk("rxrdy_low_e33", 32'(rx_ready), 32'd0);
                chk("rxdig_high_e33", 32'(rx_digitalreset), 32'd1);
    run_to(34); chk("ready_outs_e34", 32'(outs()),
                    32'({3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
    run_to(36); chk("ready_hold_e36", 32'(state), 32'd7);

    // One-cycle PLL lock drop in S_READY, then full re-sequence
    e0 = edge_n;
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    step();     chk("pllfault_not_yet", 32'(state), 32'd7);
    step();     chk("pllfault_outs", 32'(outs()), 32'(RST_OUTS));
    e0 = edge_n;
    run_to(e0 + 7);  chk("reseq_pd_e7", 32'(pll_powerdown), 32'd1);
    run_to(e0 + 8);  chk("reseq_pd_e8", 32'(pll_powerdown), 32'd0);
    run_to(e0 + 20); chk("reseq_txrdy", 32'(tx_ready), 32'd1);
    run_to(e0 + 33); chk("reseq_rxrdy_low", 32'(rx_ready), 32'd0);
    run_to(e0 + 34); chk("reseq_ready", 32'(state), 32'd7);
                     chk("reseq_rxrdy", 32'(rx_ready), 32'd1);

    // CDR lock drop in S_READY: RX only re-sequences
    step();
    e0 = edge_n;
    rx_is_lockedtodata = 1'b0;
    run_to(e0 + 2); chk("rxfault_not_yet", 32'(state), 32'd7);
    run_to(e0 + 3); chk("rxfault_outs", 32'(outs()),
                        32'({3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}));
    rx_is_lockedtodata = 1'b1;
    run_to(e0 + 7);  chk("rxfault_cdr", 32'(state), 32'd5);
    run_to(e0 + 16); chk("rxfault_rxdig", 32'(state), 32'd6);
                     chk("rxfault_txrdy", 32'(tx_ready), 32'd1);
    run_to(e0 + 17); chk("rxfault_ready", 32'(state), 32'd7);

    // Simultaneous PLL and CDR drop: PLL fault wins
    step();
    e0 = edge_n;
    pll_locked         = 1'b0;
    rx_is_lockedtodata = 1'b0;
    run_to(e0 + 3); chk("both_fault_state", 32'(state), 32'd0);
                    chk("both_fault_pd", 32'(pll_powerdown), 32'd1);
    pll_locked         = 1'b1;
    rx_is_lockedtodata = 1'b1;

    // PLL calibration busy until edge 20 holds S_PLL_LOCK
    pll_cal_busy = 1'b1;
    do_reset("reset_values_2");
    run_to(8);  chk("calbusy_lock_e8", 32'(state), 32'd1);
    run_to(20); chk("calbusy_lock_e20", 32'(state), 32'd1);
    pll_cal_busy = 1'b0;
    run_to(25); chk("calbusy_lock_e25", 32'(state), 32'd1);
    run_to(26); chk("calbusy_txana_e26", 32'(state), 32'd2);
    run_to(30); chk("calbusy_txdig_e30", 32'(state), 32'd3);

    // Asynchronous reset pulse while in S_TX_DIG
    run_to(31);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'(outs()), 32'(RST_OUTS));
    #1;
    rst_n  = 1'b1;
    edge_n = 0;

    // CDR lock drops one cycle in five: never qualifies
    while (edge_n < 80) begin
      step();
      rx_is_lockedtodata = ((edge_n % 5) != 4);
      if (edge_n == 20) chk("toggle_txrdy_e20", 32'(tx_ready), 32'd1);
      if (edge_n >= 25 && (edge_n % 11) == 0) begin
        chk("toggle_state_cdr", 32'(state), 32'd5);
        chk("toggle_rxrdy_low", 32'(rx_ready), 32'd0);
      end
    end
    chk("toggle_state_end", 32'(state), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
